// File: rtl/rp_8bit_encoder.sv
// rp_8bit_encoder: AVR instruction encoder for the rp_8bit test environment.
// The encoder takes a symbolic instruction (opcode selector plus operand fields)
// and checks the operands. It then emits the machine code as a stream of
// 16-bit program words, each tagged with a running word address.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_vld / in_rdy      instruction handshake
//   in_op                opcode selector (0..30 legal, 31..63 illegal)
//   in_rd, in_rr         destination / source register
//   in_k                 constant, I/O address, displacement or target
//   in_b                 SREG bit index for BRBS/BRBC
//   out_vld / out_rdy    program-word handshake
//   out_dat, out_lst     program word, last-word-of-instruction flag
//   out_adr              word address of out_dat
//   err                  one-cycle pulse after an illegal instruction is accepted
module rp_8bit_encoder #(
    parameter int unsigned AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [5:0]    in_op,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rr,
    input  logic [21:0]   in_k,
    input  logic [2:0]    in_b,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [15:0]   out_dat,
    output logic          out_lst,
    output logic [AW-1:0] out_adr,
    output logic          err
);

    typedef enum logic [1:0] {StEmpty, StOne, StFirst} state_e;

    state_e        state_q, state_d;
    logic [15:0]   dat_q, dat_d;
    logic [15:0]   w2_q, w2_d;
    logic [AW-1:0] adr_q, adr_d;
    logic          err_q, err_d;

    logic          accept;
    logic          consume;

    // Encoder result for the instruction currently on the input side.
    logic [15:0]   enc_w1;
    logic [15:0]   enc_w2;
    logic          enc_two;
    logic          enc_ok;

    // Operand range checks.
    logic          imm_ok;
    logic          io_ok;
    logic          rel12_ok;
    logic          rel7_ok;
    logic          abs16_ok;

    assign imm_ok   = in_rd[4];
    assign io_ok    = ~|in_k[21:6];
    // Sign-representable when all bits above the field match its sign bit.
    assign rel12_ok = (&in_k[21:11]) | ~(|in_k[21:11]);
    assign rel7_ok  = (&in_k[21:6]) | ~(|in_k[21:6]);
    assign abs16_ok = ~|in_k[21:16];

    always_comb begin
        enc_w1  = 16'h0000;
        enc_w2  = 16'h0000;
        enc_two = 1'b0;
        enc_ok  = 1'b1;
        unique case (in_op)
            6'd0:  enc_w1 = 16'h0000;
            6'd1: begin
                enc_w1 = {8'h01, in_rd[4:1], in_rr[4:1]};
                enc_ok = ~in_rd[0] & ~in_rr[0];
            end
            6'd2:  enc_w1 = {6'b000011, in_rr[4], in_rd, in_rr[3:0]};
            6'd3:  enc_w1 = {6'b000111, in_rr[4], in_rd, in_rr[3:0]};
            6'd4:  enc_w1 = {6'b000110, in_rr[4], in_rd, in_rr[3:0]};
            6'd5:  enc_w1 = {6'b001000, in_rr[4], in_rd, in_rr[3:0]};
            6'd6:  enc_w1 = {6'b001001, in_rr[4], in_rd, in_rr[3:0]};
            6'd7:  enc_w1 = {6'b001010, in_rr[4], in_rd, in_rr[3:0]};
            6'd8:  enc_w1 = {6'b001011, in_rr[4], in_rd, in_rr[3:0]};
            6'd9:  enc_w1 = {6'b000101, in_rr[4], in_rd, in_rr[3:0]};
            6'd10: begin
                enc_w1 = {4'b0011, in_k[7:4], in_rd[3:0], in_k[3:0]};
                enc_ok = imm_ok;
            end
            6'd11: begin
                enc_w1 = {4'b1110, in_k[7:4], in_rd[3:0], in_k[3:0]};
                enc_ok = imm_ok;
            end
            6'd12: begin
                enc_w1 = {4'b0101, in_k[7:4], in_rd[3:0], in_k[3:0]};
                enc_ok = imm_ok;
            end
            6'd13: begin
                enc_w1 = {4'b0110, in_k[7:4], in_rd[3:0], in_k[3:0]};
                enc_ok = imm_ok;
            end
            6'd14: begin
                enc_w1 = {4'b0111, in_k[7:4], in_rd[3:0], in_k[3:0]};
                enc_ok = imm_ok;
            end
            6'd15: enc_w1 = {7'b1001010, in_rd, 4'b0011};
            6'd16: enc_w1 = {7'b1001010, in_rd, 4'b1010};
            6'd17: enc_w1 = {7'b1001001, in_rd, 4'b1111};
            6'd18: enc_w1 = {7'b1001000, in_rd, 4'b1111};
            6'd19: begin
                enc_w1 = {5'b10110, in_k[5:4], in_rd, in_k[3:0]};
                enc_ok = io_ok;
            end
            6'd20: begin
                enc_w1 = {5'b10111, in_k[5:4], in_rd, in_k[3:0]};
                enc_ok = io_ok;
            end
            6'd21: begin
                enc_w1 = {4'b1100, in_k[11:0]};
                enc_ok = rel12_ok;
            end
            6'd22: begin
                enc_w1 = {4'b1101, in_k[11:0]};
                enc_ok = rel12_ok;
            end
            6'd23: begin
                enc_w1 = {6'b111100, in_k[6:0], in_b};
                enc_ok = rel7_ok;
            end
            6'd24: begin
                enc_w1 = {6'b111101, in_k[6:0], in_b};
                enc_ok = rel7_ok;
            end
            6'd25: enc_w1 = 16'h9508;
            6'd26: enc_w1 = 16'h9518;
            6'd27: begin
                enc_w1  = {7'b1001010, in_k[21:17], 3'b110, in_k[16]};
                enc_w2  = in_k[15:0];
                enc_two = 1'b1;
            end
            6'd28: begin
                enc_w1  = {7'b1001010, in_k[21:17], 3'b111, in_k[16]};
                enc_w2  = in_k[15:0];
                enc_two = 1'b1;
            end
            6'd29: begin
                enc_w1  = {7'b1001000, in_rd, 4'b0000};
                enc_w2  = in_k[15:0];
                enc_two = 1'b1;
                enc_ok  = abs16_ok;
            end
            6'd30: begin
                enc_w1  = {7'b1001001, in_rd, 4'b0000};
                enc_w2  = in_k[15:0];
                enc_two = 1'b1;
                enc_ok  = abs16_ok;
            end
            default: enc_ok = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            dat_q   <= 16'h0000;
            w2_q    <= 16'h0000;
            adr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            w2_q    <= w2_d;
            adr_q   <= adr_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        dat_d   = dat_q;
        w2_d    = w2_q;
        err_d   = 1'b0;
        adr_d   = adr_q + {{(AW-1){1'b0}}, consume};
        if (accept) begin
            // An accept in ONE always coincides with a consume, so the held
            // word is gone either way; an illegal instruction leaves us empty.
            err_d = ~enc_ok;
            if (enc_ok) begin
                state_d = enc_two ? StFirst : StOne;
                dat_d   = enc_w1;
                w2_d    = enc_w2;
            end else begin
                state_d = StEmpty;
            end
        end else if (consume) begin
            if (state_q == StFirst) begin
                state_d = StOne;
                dat_d   = w2_q;
            end else begin
                state_d = StEmpty;
            end
        end
    end

    // Outputs.
    always_comb begin
        out_vld = (state_q != StEmpty);
        out_lst = (state_q == StOne);
        out_dat = dat_q;
        out_adr = adr_q;
        err     = err_q;
        in_rdy  = (state_q == StEmpty) | ((state_q == StOne) & out_rdy);
        consume = out_vld & out_rdy;
        accept  = in_vld & in_rdy;
    end

endmodule

// File: tb/tb_rp_8bit_encoder.sv
// Directed bench for rp_8bit_encoder. Inputs change and outputs are sampled on
// the falling clock edge, away from the active rising edge.
module tb_rp_8bit_encoder;

    logic        clk;
    logic        rst;
    logic        in_vld;
    logic        in_rdy;
    logic [5:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rr;
    logic [21:0] in_k;
    logic [2:0]  in_b;
    logic        out_vld;
    logic        out_rdy;
    logic [15:0] out_dat;
    logic        out_lst;
    logic [15:0] out_adr;
    logic        err;

    int total;
    int bad;

    rp_8bit_encoder #(.AW(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_op   (in_op),
        .in_rd   (in_rd),
        .in_rr   (in_rr),
        .in_k    (in_k),
        .in_b    (in_b),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_dat (out_dat),
        .out_lst (out_lst),
        .out_adr (out_adr),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rr,
                         input logic [21:0] k, input logic [2:0] b);
        in_vld = 1'b1;
        in_op  = op;
        in_rd  = rd;
        in_rr  = rr;
        in_k   = k;
        in_b   = b;
    endtask

    task automatic idle();
        in_vld = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        drive(6'd0, 5'd0, 5'd0, 22'd0, 3'd0);
        idle();
        repeat (2) @(negedge clk);
        total++;
        if (out_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got %b exp 0", out_vld); end
        total++;
        if (out_dat !== 16'h0000) begin bad++; $display("FAIL reset_dat got %h exp 0000", out_dat); end
        total++;
        if (out_lst !== 1'b0) begin bad++; $display("FAIL reset_lst got %b exp 0", out_lst); end
        total++;
        if (out_adr !== 16'h0000) begin bad++; $display("FAIL reset_adr got %h exp 0000", out_adr); end
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL reset_err got %b exp 0", err); end
        total++;
        if (in_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got %b exp 1", in_rdy); end
        rst = 1'b0;
    endtask

    task automatic test_one_word();
        do_reset();
        out_rdy = 1'b1;
        @(negedge clk);
        drive(6'd11, 5'd16, 5'd0, 22'h0000AB, 3'd0);   // LDI r16,0xAB
        @(negedge clk);
        total++;
        if (out_vld !== 1'b1 || out_dat !== 16'hEA0B || out_lst !== 1'b1 || out_adr !== 16'd0) begin
            bad++;
            $display("FAIL ldi got vld=%b dat=%h lst=%b adr=%0d exp 1 EA0B 1 0",
                     out_vld, out_dat, out_lst, out_adr);
        end
        drive(6'd2, 5'd1, 5'd2, 22'd0, 3'd0);            // ADD r1,r2
        @(negedge clk);
        idle();
        total++;
        if (out_vld !== 1'b1 || out_dat !== 16'h0C12 || out_lst !== 1'b1 || out_adr !== 16'd1) begin
            bad++;
            $display("FAIL add got vld=%b dat=%h lst=%b adr=%0d exp 1 0C12 1 1",
                     out_vld, out_dat, out_lst, out_adr);
        end
        @(negedge clk);
        total++;
        if (out_vld !== 1'b0 || out_adr !== 16'd2) begin
            bad++;
            $display("FAIL drain got vld=%b adr=%0d exp 0 2", out_vld, out_adr);
        end
    endtask

    task automatic test_stream();
        logic [15:0] exp_dat [4];
        logic        exp_lst [4];
        do_reset();
        exp_dat = '{16'h0000, 16'h9508, 16'h940E, 16'h0000};
        exp_lst = '{1'b1, 1'b1, 1'b0, 1'b1};
        out_rdy = 1'b1;
        @(negedge clk);
        drive(6'd0, 5'd0, 5'd0, 22'd0, 3'd0);            // NOP
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) drive(6'd25, 5'd0, 5'd0, 22'd0, 3'd0);       // RET
            else if (i == 1) drive(6'd28, 5'd0, 5'd0, 22'd0, 3'd0);  // CALL 0
            else idle();
            total++;
            if (out_vld !== 1'b1 || out_dat !== exp_dat[i] || out_lst !== exp_lst[i] ||
                out_adr !== 16'(i)) begin
                bad++;
                $display("FAIL stream%0d got vld=%b dat=%h lst=%b adr=%0d exp 1 %h %b %0d",
                         i, out_vld, out_dat, out_lst, out_adr, exp_dat[i], exp_lst[i], i);
            end
            if (i == 2) begin
                total++;
                if (in_rdy !== 1'b0) begin bad++; $display("FAIL stream_rdy_first got %b exp 0", in_rdy); end
            end
        end
        @(negedge clk);
        total++;
        if (out_vld !== 1'b0 || out_adr !== 16'd4) begin
            bad++;
            $display("FAIL stream_end got vld=%b adr=%0d exp 0 4", out_vld, out_adr);
        end
    endtask

    task automatic test_stall();
        do_reset();
        out_rdy = 1'b0;
        @(negedge clk);
        drive(6'd27, 5'd0, 5'd0, 22'h012345, 3'd0);      // JMP 0x012345
        @(negedge clk);
        idle();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_vld !== 1'b1 || out_dat !== 16'h940D || out_lst !== 1'b0 ||
                out_adr !== 16'd0 || in_rdy !== 1'b0) begin
                bad++;
                $display("FAIL stall%0d got vld=%b dat=%h lst=%b adr=%0d rdy=%b exp 1 940D 0 0 0",
                         i, out_vld, out_dat, out_lst, out_adr, in_rdy);
            end
            if (i < 2) @(negedge clk);
        end
        out_rdy = 1'b1;
        @(negedge clk);
        total++;
        if (out_vld !== 1'b1 || out_dat !== 16'h2345 || out_lst !== 1'b1 || out_adr !== 16'd1) begin
            bad++;
            $display("FAIL jmp_w2 got vld=%b dat=%h lst=%b adr=%0d exp 1 2345 1 1",
                     out_vld, out_dat, out_lst, out_adr);
        end
        total++;
        if (in_rdy !== 1'b1) begin bad++; $display("FAIL one_rdy got %b exp 1", in_rdy); end
        out_rdy = 1'b0;
        #1;
        total++;
        if (in_rdy !== 1'b0) begin bad++; $display("FAIL one_stall_rdy got %b exp 0", in_rdy); end
        out_rdy = 1'b1;
        @(negedge clk);
        total++;
        if (out_vld !== 1'b0 || out_adr !== 16'd2) begin
            bad++;
            $display("FAIL stall_end got vld=%b adr=%0d exp 0 2", out_vld, out_adr);
        end
    endtask

    task automatic test_illegal();
        logic [5:0]  ops [5];
        logic [4:0]  rds [5];
        logic [21:0] ks  [5];
        do_reset();
        ops = '{6'd11, 6'd1, 6'd19, 6'd21, 6'd40};
        rds = '{5'd5, 5'd3, 5'd0, 5'd0, 5'd0};
        ks  = '{22'h0000AB, 22'd0, 22'd64, 22'h000800, 22'd0};
        out_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(ops[i], rds[i], 5'd0, ks[i], 3'd0);
            @(negedge clk);
            idle();
            total++;
            if (err !== 1'b1 || out_vld !== 1'b0 || out_adr !== 16'd0) begin
                bad++;
                $display("FAIL illegal%0d got err=%b vld=%b adr=%0d exp 1 0 0",
                         i, err, out_vld, out_adr);
            end
            @(negedge clk);
            total++;
            if (err !== 1'b0 || out_vld !== 1'b0) begin
                bad++;
                $display("FAIL illegal%0d_pulse got err=%b vld=%b exp 0 0", i, err, out_vld);
            end
        end
        // Illegal accept in ONE together with a consume.
        drive(6'd15, 5'd3, 5'd0, 22'd0, 3'd0);           // INC r3
        @(negedge clk);
        total++;
        if (out_vld !== 1'b1 || out_dat !== 16'h9433 || err !== 1'b0) begin
            bad++;
            $display("FAIL inc got vld=%b dat=%h err=%b exp 1 9433 0", out_vld, out_dat, err);
        end
        drive(6'd11, 5'd5, 5'd0, 22'd0, 3'd0);           // LDI r5 (illegal)
        @(negedge clk);
        idle();
        total++;
        if (out_vld !== 1'b0 || err !== 1'b1 || out_adr !== 16'd1) begin
            bad++;
            $display("FAIL one_illegal got vld=%b err=%b adr=%0d exp 0 1 1", out_vld, err, out_adr);
        end
    endtask

    task automatic test_signed();
        logic [5:0]  ops [4];
        logic [4:0]  rds [4];
        logic [4:0]  rrs [4];
        logic [21:0] ks  [4];
        logic [2:0]  bs  [4];
        logic [15:0] exp_dat [4];
        do_reset();
        ops     = '{6'd21, 6'd21, 6'd24, 6'd1};
        rds     = '{5'd0, 5'd0, 5'd0, 5'd2};
        rrs     = '{5'd0, 5'd0, 5'd0, 5'd4};
        ks      = '{22'h3FFFFF, 22'h3FF800, 22'h3FFFC0, 22'd0};
        bs      = '{3'd0, 3'd0, 3'd1, 3'd0};
        exp_dat = '{16'hCFFF, 16'hC800, 16'hF601, 16'h0112};
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(ops[i], rds[i], rrs[i], ks[i], bs[i]);
            @(negedge clk);
            idle();
            total++;
            if (out_vld !== 1'b1 || out_dat !== exp_dat[i] || out_lst !== 1'b1 ||
                out_adr !== 16'(i) || err !== 1'b0) begin
                bad++;
                $display("FAIL signed%0d got vld=%b dat=%h lst=%b adr=%0d err=%b exp 1 %h 1 %0d 0",
                         i, out_vld, out_dat, out_lst, out_adr, err, exp_dat[i], i);
            end
        end
    endtask

    task automatic test_reset_first();
        do_reset();
        out_rdy = 1'b0;
        @(negedge clk);
        drive(6'd27, 5'd0, 5'd0, 22'h012345, 3'd0);      // JMP
        @(negedge clk);
        idle();
        total++;
        if (out_vld !== 1'b1 || out_lst !== 1'b0) begin
            bad++;
            $display("FAIL first_pre got vld=%b lst=%b exp 1 0", out_vld, out_lst);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_vld !== 1'b0) begin bad++; $display("FAIL async_rst_vld got %b exp 0", out_vld); end
        @(negedge clk);
        rst = 1'b0;
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (out_vld !== 1'b0 || out_adr !== 16'd0 || out_dat !== 16'h0000) begin
                bad++;
                $display("FAIL post_rst%0d got vld=%b adr=%0d dat=%h exp 0 0 0000",
                         i, out_vld, out_adr, out_dat);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_one_word();
        test_stream();
        test_stall();
        test_illegal();
        test_signed();
        test_reset_first();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rp_8bit_encoder.md
# rp_8bit_encoder

Instruction encoder for the rp_8bit core's test environment. It is the inverse of the disassembler: it accepts a symbolic instruction as an opcode selector plus operand fields, checks the operands for legality, and emits the AVR machine code as a stream of 16-bit program words. Each word carries a running word address. Benches use it to build program memory images and to drive instruction fetch directly; its output is suitable for round-trip checking against the disassembler.

## Interface
- AW, 16, width of the word address counter `out_adr`.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_vld`  in  1  instruction valid.
- `in_rdy`  out  1  instruction accepted when `in_vld & in_rdy`.
- `in_op`  in  6  opcode selector (list below).
- `in_rd`  in  5  destination register.
- `in_rr`  in  5  source register.
- `in_k`  in  22  constant, I/O address, displacement or target; two's complement where signed.
- `in_b`  in  3  SREG bit index.
- `out_vld`  out  1  word valid.
- `out_rdy`  in  1  word consumed when `out_vld & out_rdy`.
- `out_dat`  out  16  program word.
- `out_lst`  out  1  last word of the instruction.
- `out_adr`  out  AW  word address of `out_dat`.
- `err`  out  1  one-cycle pulse: the accepted instruction was illegal.

## Operation
- Opcode selectors and their encodings. `d` = `in_rd`, `r` = `in_rr`, `K` = `in_k[7:0]`. `d'` is `in_rd[3:0]`; `d'` and `r'` are the register number divided by 2 for MOVW.
  - 0 NOP 0x0000.
  - 1 MOVW 0x01 followed by `d'r'`.
  - 2 ADD 0000_11rd_dddd_rrrr.
  - 3 ADC 0001_11.
  - 4 SUB 0001_10.
  - 5 AND 0010_00.
  - 6 EOR 0010_01.
  - 7 OR 0010_10.
  - 8 MOV 0010_11.
  - 9 CP 0001_01.
  - 10 CPI 0011_KKKK_dddd_KKKK.
  - 11 LDI 1110.
  - 12 SUBI 0101.
  - 13 ORI 0110.
  - 14 ANDI 0111.
  - 15 INC 1001_010d_dddd_0011.
  - 16 DEC 1001_010d_dddd_1010.
  - 17 PUSH 1001_001d_dddd_1111.
  - 18 POP 1001_000d_dddd_1111.
  - 19 IN 1011_0AAd_dddd_AAAA.
  - 20 OUT 1011_1AA.
  - 21 RJMP 1100_k[11:0].
  - 22 RCALL 1101_k[11:0].
  - 23 BRBS 1111_00k[6:0]bbb.
  - 24 BRBC 1111_01k[6:0]bbb.
  - 25 RET 0x9508.
  - 26 RETI 0x9518.
  - 27 JMP 1001_010k[21:17]_110k[16], then k[15:0].
  - 28 CALL, as JMP with 111.
  - 29 LDS 1001_000d_dddd_0000, then k[15:0].
  - 30 STS 1001_001d_dddd_0000, then k[15:0].
- Selectors 31–63 are illegal.
- Legality checks; any failure makes the instruction illegal:
  - Immediate ops (10–14) need `in_rd` ≥ 16.
  - MOVW needs `in_rd[0]` = 0 and `in_rr[0]` = 0.
  - IN/OUT need `in_k` < 64.
  - RJMP/RCALL need `in_k` sign-representable in 12 bits, i.e. `in_k[21:11]` all equal.
  - BRBS/BRBC need `in_k[21:6]` all equal.
  - LDS/STS need `in_k[21:16]` = 0.
  - Fields unused by an opcode are ignored.
- An illegal instruction is accepted: no word is emitted, `err` pulses, `out_adr` does not advance.
- State machine, output-registered:
  - EMPTY: no word held.
  - ONE: holding the only word or the second word of an instruction; `out_lst` = 1.
  - FIRST: holding word 1 of a 2-word instruction; word 2 is held in an internal register.
- Transitions:
  - EMPTY + accept legal 1-word instruction → ONE.
  - EMPTY + accept legal 2-word instruction → FIRST.
  - FIRST + consume → ONE, loading word 2.
  - ONE + consume, with no accept → EMPTY.
  - ONE + consume + accept → ONE or FIRST, for the new instruction.
- `in_rdy` = (state == EMPTY) | (state == ONE & `out_rdy`). It is combinational from state and `out_rdy`.
- `out_adr` increments by 1 after each consumed word and wraps modulo 2^AW.

## Timing
- Reset values: state EMPTY, `out_vld` 0, `out_dat` 0x0000, `out_lst` 0, `out_adr` 0, `err` 0. Reset is effective immediately and discards any held words.
- Latency:
  - Instruction accepted at edge N → word 1 presented from edge N+1.
  - Word 2 is presented one cycle after word 1 is consumed.
  - `err` is high for exactly the cycle after the edge that accepted the illegal instruction.
- Throughput: one word per cycle with `out_rdy` held high, so back-to-back 1-word instructions flow without bubbles.
- Stalls:
  - While `out_vld` & !`out_rdy`, `out_dat`, `out_lst` and `out_adr` hold stable.
  - `in_rdy` is 0 in FIRST, and in ONE while `out_rdy` is 0.
- An illegal accept in state ONE coincident with a consume → EMPTY next cycle, `err` = 1.

## Test plan
- Legal 1-word encodings, `out_rdy` = 1:
  - LDI `in_rd`=16 `in_k`=0xAB → 0xEA0B.
  - ADD r1,r2 → 0x0C12.
  - Each word with `out_lst` = 1, `out_adr` 0 then 1.
- Stream NOP, RET, CALL 0 with `out_rdy` = 1 → 0x0000, 0x9508, 0x940E, 0x0000 on consecutive cycles; `out_adr` 0..3; `out_lst` pattern 1,1,0,1.
- JMP `in_k`=0x012345 with `out_rdy` low for 3 cycles:
  - 0x940D held stable with `out_lst` = 0 and `in_rdy` = 0.
  - After release, next word is 0x2345 with `out_lst` = 1.
- Illegal operands each give one `err` pulse, no `out_vld`, and `out_adr` unchanged:
  - LDI `in_rd`=5.
  - MOVW `in_rd`=3.
  - IN `in_k`=64.
  - RJMP `in_k`=0x000800.
  - Opcode 40.
- Signed edge values:
  - RJMP `in_k`=0x3FFFFF → 0xCFFF.
  - RJMP `in_k`=0x3FF800 → 0xC800.
  - BRBC `in_k`=0x3FFFC0, `in_b`=1 → 0xF601.
- Assert `rst` while in FIRST → `out_vld` 0 in the same cycle; after release, `out_adr` = 0 and word 2 is never emitted.
